// File: rtl/phys_reg_free_list_pkg.sv
// Free-list shared types and reset map helper.
// Optional restore ports are enabled by FREELIST_RESTORE_EN (see top).
package freelist_pkg;

  localparam int NUM_PREGS_DEFAULT = 64;
  localparam int NUM_ARCH_DEFAULT  = 32;

  typedef logic [$clog2(NUM_PREGS_DEFAULT)-1:0] preg_t;

  // Pregs below num_arch hold the identity map, so only the rest start free.
  function automatic logic [63:0] init_map(input int np, input int na);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      m[i] = (i >= na) && (i < np);
    end
    return m;
  endfunction

endpackage

// File: rtl/phys_reg_free_list_priority_encoder.sv
// Priority encoder: highest set bit on out_MSB_o, lowest on out_LSB_o
// when TWO_SIDE is set, valid_o when any input bit is set.
module priority_encoder #(
  parameter int WIDTH    = 64,
  parameter bit TWO_SIDE = 1'b0,
  localparam int W       = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [W-1:0]     out_MSB_o,
  output logic [W-1:0]     out_LSB_o,
  output logic             valid_o
);

  always_comb begin
    out_MSB_o = '0;
    valid_o   = |in_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) out_MSB_o = W'(i);
    end
  end

  generate
    if (TWO_SIDE) begin : g_lsb
      always_comb begin
        out_LSB_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (in_i[i]) out_LSB_o = W'(i);
        end
      end
    end else begin : g_no_lsb
      assign out_LSB_o = '0;
    end
  endgenerate

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register free list with a one-entry prefetch buffer.
// FREELIST_RESTORE_EN adds restore_valid_i/restore_map_i for recovery.
module phys_reg_free_list
  import freelist_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEFAULT,
  parameter int NUM_ARCH  = NUM_ARCH_DEFAULT,
  localparam int PW       = $clog2(NUM_PREGS),
  localparam int CW       = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req_i,
  output logic                 alloc_valid_o,
  output logic [PW-1:0]        alloc_preg_o,
  input  logic                 free_valid_i,
  input  logic [PW-1:0]        free_preg_i,
  output logic [CW-1:0]        free_count_o,
  output logic                 empty_o
`ifdef FREELIST_RESTORE_EN
  ,
  input  logic                 restore_valid_i,
  input  logic [NUM_PREGS-1:0] restore_map_i
`endif
);

  localparam logic [63:0] INIT_FULL =
    init_map(NUM_PREGS, NUM_ARCH);
  localparam logic [NUM_PREGS-1:0] INIT_MAP =
    INIT_FULL[NUM_PREGS-1:0];

  function automatic logic [CW-1:0] popcount(
    input logic [NUM_PREGS-1:0] v
  );
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic [NUM_PREGS-1:0] bitmap_q, bitmap_d;
  logic                 alloc_valid_q, alloc_valid_d;
  logic [PW-1:0]        alloc_preg_q, alloc_preg_d;
  logic [PW-1:0]        enc_msb, enc_lsb;
  logic                 enc_valid;
  logic                 pop, refill, free_en, free_chk;
  logic                 unused_lsb;

  priority_encoder #(
    .WIDTH   (NUM_PREGS),
    .TWO_SIDE(1'b0)
  ) u_enc (
    .in_i     (bitmap_q),
    .out_MSB_o(enc_msb),
    .out_LSB_o(enc_lsb),
    .valid_o  (enc_valid)
  );

  assign unused_lsb = ^enc_lsb;

  assign pop     = alloc_req_i & alloc_valid_q;
  assign refill  = (~alloc_valid_q | pop) & enc_valid;
  assign free_en = free_valid_i & (free_preg_i != '0);

`ifdef FREELIST_RESTORE_EN
  assign free_chk = free_en & ~restore_valid_i;
`else
  assign free_chk = free_en;
`endif

  // Free and refill always hit different pregs, so both edits apply.
  always_comb begin
    bitmap_d      = bitmap_q;
    alloc_valid_d = alloc_valid_q;
    alloc_preg_d  = alloc_preg_q;
`ifdef FREELIST_RESTORE_EN
    if (restore_valid_i) begin
      bitmap_d      = {restore_map_i[NUM_PREGS-1:1], 1'b0};
      alloc_valid_d = 1'b0;
    end else
`endif
    begin
      if (free_en) bitmap_d[free_preg_i] = 1'b1;
      if (refill) begin
        bitmap_d[enc_msb] = 1'b0;
        alloc_valid_d     = 1'b1;
        alloc_preg_d      = enc_msb;
      end else if (pop) begin
        alloc_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q      <= INIT_MAP;
      alloc_valid_q <= 1'b0;
      alloc_preg_q  <= '0;
    end else begin
      bitmap_q      <= bitmap_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_preg_q  <= alloc_preg_d;
    end
  end

  assign alloc_valid_o = alloc_valid_q;
  assign alloc_preg_o  = alloc_preg_q;
  assign free_count_o  = rst ? '0 :
    popcount(bitmap_q) + CW'(alloc_valid_q);
  assign empty_o       = (free_count_o == '0);

  // A preg may only come back while it is neither free nor buffered.
  a_free_legal: assert property (
    @(posedge clk) disable iff (rst)
    free_chk |-> !bitmap_q[free_preg_i] &&
      !(alloc_valid_q && alloc_preg_q == free_preg_i)
  );

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus random
// traffic against a pool-of-free-pregs reference model.
module tb_phys_reg_free_list;
  import freelist_pkg::*;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int PW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alloc_req_i = 1'b0;
  logic          alloc_valid_o;
  logic [PW-1:0] alloc_preg_o;
  logic          free_valid_i = 1'b0;
  logic [PW-1:0] free_preg_i = '0;
  logic [CW-1:0] free_count_o;
  logic          empty_o;
  logic          rv_t = 1'b0;
  logic [63:0]   rm_t = '0;
`ifdef FREELIST_RESTORE_EN
  logic          restore_valid_i = 1'b0;
  logic [NP-1:0] restore_map_i = '0;
`endif

  int errors = 0;
  int checks = 0;

  phys_reg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req_i  (alloc_req_i),
    .alloc_valid_o(alloc_valid_o),
    .alloc_preg_o (alloc_preg_o),
    .free_valid_i (free_valid_i),
    .free_preg_i  (free_preg_i),
    .free_count_o (free_count_o),
`ifdef FREELIST_RESTORE_EN
    .restore_valid_i(restore_valid_i),
    .restore_map_i  (restore_map_i),
`endif
    .empty_o      (empty_o)
  );

  always #5 clk = ~clk;

  // Reference: set of free pregs plus the one-entry output buffer.
  bit pool[NP];
  bit bv;
  int bp;

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) pool[i] = (i >= NA);
    bv = 1'b0;
    bp = 0;
  endfunction

  function automatic int mcount();
    int n;
    n = bv ? 1 : 0;
    for (int i = 0; i < NP; i++) n += pool[i] ? 1 : 0;
    return n;
  endfunction

  function automatic void model_edge(bit req, bit fv, int fp);
    int top;
    bit pop;
    if (rst) begin
      model_reset();
      return;
    end
    if (rv_t) begin
      for (int i = 0; i < NP; i++) pool[i] = rm_t[i];
      pool[0] = 1'b0;
      bv = 1'b0;
      return;
    end
    top = -1;
    for (int i = 0; i < NP; i++) if (pool[i]) top = i;
    pop = req && bv;
    if (fv && fp != 0) pool[fp] = 1'b1;
    if ((!bv || pop) && top >= 0) begin
      pool[top] = 1'b0;
      bv = 1'b1;
      bp = top;
    end else if (pop) begin
      bv = 1'b0;
    end
  endfunction

  task automatic step(input bit req, input bit fv, input int fp);
    alloc_req_i  = req;
    free_valid_i = fv;
    free_preg_i  = PW'(fp);
`ifdef FREELIST_RESTORE_EN
    restore_valid_i = rv_t;
    restore_map_i   = rm_t;
`endif
    @(posedge clk);
    model_edge(req, fv, fp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 0);
    step(1, 0, 0);
    checks++;
    if (alloc_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %0d want 0", alloc_valid_o);
    end
    checks++;
    if (free_count_o !== 7'd0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_count: got %0d/%0d want 0/1",
               free_count_o, empty_o);
    end
    checks++;
    if (alloc_preg_o !== 6'd0) begin
      errors++;
      $display("FAIL rst_preg: got %0d want 0", alloc_preg_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (alloc_valid_o !== 1'b0 || free_count_o !== 7'd32) begin
      errors++;
      $display("FAIL cyc1: got v=%0d c=%0d want v=0 c=32",
               alloc_valid_o, free_count_o);
    end
    step(0, 0, 0);
    checks++;
    if (alloc_valid_o !== 1'b1 || alloc_preg_o !== 6'd63 ||
        free_count_o !== 7'd32) begin
      errors++;
      $display("FAIL cyc2: got v=%0d p=%0d c=%0d want 1/63/32",
               alloc_valid_o, alloc_preg_o, free_count_o);
    end
  endtask

  task automatic test_burst();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (alloc_valid_o !== 1'b1 || alloc_preg_o !== PW'(63 - k)) begin
        errors++;
        $display("FAIL burst_preg%0d: got %0d want %0d",
                 k, alloc_preg_o, 63 - k);
      end
      step(1, 0, 0);
      checks++;
      if (free_count_o !== CW'(31 - k)) begin
        errors++;
        $display("FAIL burst_count%0d: got %0d want %0d",
                 k, free_count_o, 31 - k);
      end
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 28; k++) step(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (alloc_valid_o !== 1'b0 || empty_o !== 1'b1 ||
          free_count_o !== 7'd0) begin
        errors++;
        $display("FAIL drain%0d: got v=%0d e=%0d c=%0d want 0/1/0",
                 k, alloc_valid_o, empty_o, free_count_o);
      end
      step(1, 0, 0);
    end
  endtask

  task automatic test_free_empty();
    step(0, 1, 40);
    checks++;
    if (free_count_o !== 7'd1 || alloc_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL free40_c1: got c=%0d v=%0d want 1/0",
               free_count_o, alloc_valid_o);
    end
    step(0, 0, 0);
    checks++;
    if (alloc_valid_o !== 1'b1 || alloc_preg_o !== 6'd40 ||
        free_count_o !== 7'd1) begin
      errors++;
      $display("FAIL free40_c2: got v=%0d p=%0d c=%0d want 1/40/1",
               alloc_valid_o, alloc_preg_o, free_count_o);
    end
    step(0, 1, 0);
    checks++;
    if (free_count_o !== 7'd1 || empty_o !== 1'b0) begin
      errors++;
      $display("FAIL free0: got c=%0d e=%0d want 1/0",
               free_count_o, empty_o);
    end
  endtask

  task automatic test_pop_free();
    do_reset();
    step(1, 1, 17);
    checks++;
    if (alloc_preg_o !== 6'd62 || free_count_o !== 7'd32) begin
      errors++;
      $display("FAIL popfree: got p=%0d c=%0d want 62/32",
               alloc_preg_o, free_count_o);
    end
    step(1, 0, 0);
    checks++;
    if (alloc_preg_o !== 6'd61 || free_count_o !== 7'd31) begin
      errors++;
      $display("FAIL popfree2: got p=%0d c=%0d want 61/31",
               alloc_preg_o, free_count_o);
    end
  endtask

`ifdef FREELIST_RESTORE_EN
  task automatic test_restore();
    do_reset();
    step(1, 0, 0);
    rv_t = 1'b1;
    rm_t = 64'hFFFF_0000_0000_0001;
    step(1, 1, 5);
    rv_t = 1'b0;
    checks++;
    if (alloc_valid_o !== 1'b0 || free_count_o !== 7'd16) begin
      errors++;
      $display("FAIL restore1: got v=%0d c=%0d want 0/16",
               alloc_valid_o, free_count_o);
    end
    step(0, 0, 0);
    checks++;
    if (alloc_valid_o !== 1'b1 || alloc_preg_o !== 6'd63 ||
        free_count_o !== 7'd16) begin
      errors++;
      $display("FAIL restore2: got v=%0d p=%0d c=%0d want 1/63/16",
               alloc_valid_o, alloc_preg_o, free_count_o);
    end
  endtask
`endif

  task automatic test_random();
    int cand[$];
    int fp;
    bit fv;
    int exp_c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cand.delete();
      for (int i = 1; i < NP; i++) begin
        if (!pool[i] && !(bv && bp == i)) cand.push_back(i);
      end
      fv = ($urandom_range(2) != 0) && (cand.size() > 0);
      fp = fv ? cand[$urandom_range(cand.size() - 1)] : 0;
      rst = ($urandom_range(99) == 0);
`ifdef FREELIST_RESTORE_EN
      rv_t = ($urandom_range(49) == 0);
      rm_t = {$urandom, $urandom};
`endif
      step(($urandom_range(2) != 0), fv, fp);
      exp_c = rst ? 0 : mcount();
      checks++;
      if (alloc_valid_o !== bv) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %0d want %0d",
                 n, alloc_valid_o, bv);
      end
      if (bv) begin
        checks++;
        if (alloc_preg_o !== PW'(bp)) begin
          errors++;
          $display("FAIL rnd_preg@%0d: got %0d want %0d",
                   n, alloc_preg_o, bp);
        end
      end
      checks++;
      if (free_count_o !== CW'(exp_c) ||
          empty_o !== (exp_c == 0)) begin
        errors++;
        $display("FAIL rnd_count@%0d: got %0d/%0d want %0d",
                 n, free_count_o, empty_o, exp_c);
      end
    end
    rst = 1'b0;
    rv_t = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_burst();
    test_drain();
    test_free_empty();
    test_pop_free();
`ifdef FREELIST_RESTORE_EN
    test_restore();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
